// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi
//   Multi-channel servo PWM generator. Each channel has a programmable high
//   time written through a valid/ready command port. Commands are clamped to
//   [MIN_CYC, MAX_CYC] and set the channel's target width. The width that is
//   actually output (cur) follows the target only at frame boundaries, so a
//   pulse never changes shape mid-frame.
//
//   Optional feature (compile-time macro SERVO_SLEW_EN):
//     defined   - cur moves toward tgt by at most SLEW_STEP per frame
//     undefined - cur jumps to tgt at each boundary (SLEW_STEP ignored)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   command can be accepted (high whenever out of reset)
//   cmd_ch      target channel; indices >= CHANNELS are accepted and dropped
//   cmd_width   requested high time in clk cycles
//   enable      per-channel output enable
//   control     PWM outputs
//   frame_start one-cycle pulse in the first cycle of each frame
//   busy        per-channel: current width differs from target
module servo_pwm_multi #(
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned CNT_W      = 24,
   parameter int unsigned PERIOD_CYC = 2_000_000,
   parameter int unsigned MIN_CYC    = 100_000,
   parameter int unsigned MAX_CYC    = 200_000,
   parameter int unsigned SLEW_STEP  = 5_000,
   parameter int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [CH_W-1:0]     cmd_ch,
   input  logic [CNT_W-1:0]    cmd_width,
   input  logic [CHANNELS-1:0] enable,
   output logic [CHANNELS-1:0] control,
   output logic                frame_start,
   output logic [CHANNELS-1:0] busy
);

   localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_CYC);
   localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_CYC);
   localparam logic [CNT_W-1:0] MID_W    = CNT_W'((MIN_CYC + MAX_CYC) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
`ifdef SERVO_SLEW_EN
   localparam logic [CNT_W-1:0] STEP_W   = CNT_W'(SLEW_STEP);
`endif

   if (!(PERIOD_CYC > MAX_CYC && MAX_CYC >= MIN_CYC && MIN_CYC >= 1)) begin : g_bad_timing
      $error("servo_pwm_multi: need PERIOD_CYC > MAX_CYC >= MIN_CYC >= 1");
   end
   if (CHANNELS < 1 || CHANNELS > 16 || (CHANNELS > 1 && CH_W < $clog2(CHANNELS))) begin : g_bad_ch
      $error("servo_pwm_multi: CHANNELS must be 1..16 and CH_W wide enough to index them");
   end
   if (64'(PERIOD_CYC) > (64'd1 << CNT_W) || 64'(SLEW_STEP) >= (64'd1 << CNT_W)) begin : g_bad_width
      $error("servo_pwm_multi: CNT_W too narrow for PERIOD_CYC or SLEW_STEP");
   end

   logic [CNT_W-1:0]    cnt;
   logic                wrap;
   logic [CNT_W-1:0]    cur     [CHANNELS];
   logic [CNT_W-1:0]    tgt     [CHANNELS];
   logic [CNT_W-1:0]    tgt_nxt [CHANNELS];
   logic [CNT_W-1:0]    cur_nxt [CHANNELS];
   logic [CNT_W-1:0]    cmd_clamped;
   logic                cmd_acc;
   logic [CHANNELS-1:0] arm;

   assign cmd_ready = rst_n;
   assign cmd_acc   = cmd_valid & cmd_ready;
   assign wrap      = (cnt == LAST_CNT);

   assign cmd_clamped = (cmd_width < MIN_W) ? MIN_W :
                        (cmd_width > MAX_W) ? MAX_W : cmd_width;

   // Target after this cycle's command, and the width the next frame would use.
   // Using tgt_nxt (not tgt) lets a command in the boundary cycle take effect
   // at that same boundary.
   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         tgt_nxt[i] = tgt[i];
         if (cmd_acc && cmd_ch == CH_W'(i))
            tgt_nxt[i] = cmd_clamped;
`ifdef SERVO_SLEW_EN
         if (tgt_nxt[i] > cur[i])
            cur_nxt[i] = ((tgt_nxt[i] - cur[i]) > STEP_W) ? cur[i] + STEP_W : tgt_nxt[i];
         else
            cur_nxt[i] = ((cur[i] - tgt_nxt[i]) > STEP_W) ? cur[i] - STEP_W : tgt_nxt[i];
`else
         cur_nxt[i] = tgt_nxt[i];
`endif
      end
   end

   always_comb begin
      busy = '0;
      for (int unsigned i = 0; i < CHANNELS; i++)
         busy[i] = (cur[i] != tgt[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cur[i] <= MID_W;
            tgt[i] <= MID_W;
         end
      end else begin
         cnt <= wrap ? '0 : cnt + CNT_W'(1);
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            tgt[i] <= tgt_nxt[i];
            if (wrap)
               cur[i] <= cur_nxt[i];
         end
      end
   end

   // arm[i] records that the channel has been continuously enabled since the
   // start of the current frame; a channel re-enabled mid-frame stays low
   // until the next frame begins instead of emitting a truncated pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_start <= 1'b0;
         control     <= '0;
         arm         <= '0;
      end else begin
         frame_start <= (cnt == '0);
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            arm[i]     <= enable[i] & (arm[i] | (cnt == '0));
            control[i] <= enable[i] & (arm[i] | (cnt == '0)) & (cnt < cur[i]);
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
module tb_servo_pwm_multi;

   localparam int NCH  = 4;
   localparam int CW   = 24;
   localparam int P    = 1000;
   localparam int MINC = 50;
   localparam int MAXC = 100;
   localparam int STEP = 10;
   localparam int MID  = (MINC + MAXC) / 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_ch = '0;
   logic [CW-1:0] cmd_width = '0;
   logic [3:0]    enable = 4'hF;
   logic [3:0]    control;
   logic          frame_start;
   logic [3:0]    busy;

   always #5 clk = ~clk;

   servo_pwm_multi #(
      .CHANNELS  (NCH),
      .CNT_W     (CW),
      .PERIOD_CYC(P),
      .MIN_CYC   (MINC),
      .MAX_CYC   (MAXC),
      .SLEW_STEP (STEP),
      .CH_W      (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ch     (cmd_ch),
      .cmd_width  (cmd_width),
      .enable     (enable),
      .control    (control),
      .frame_start(frame_start),
      .busy       (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: per-channel target and in-use widths, advanced once per frame.
   int tgt_m [NCH];
   int cur_m [NCH];

   typedef struct {
      int     off;
      int     ch;
      longint w;
   } cmd_t;
   cmd_t cmd_q[$];

   int         drop_at = -1;
   int         back_at = -1;
   int         snap_at = -1;
   logic [3:0] snap_busy;
   logic [3:0] snap_ctrl;
   int         hi [NCH];
   int         len;
   bit         ok;
   int         exp_w [NCH];

   function automatic int clamp_w(longint w);
      if (w < MINC) return MINC;
      if (w > MAXC) return MAXC;
      return int'(w);
   endfunction

   function automatic void apply_cmd(int ch, longint w);
      if (ch < NCH) tgt_m[ch] = clamp_w(w);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         tgt_m[i] = MID;
         cur_m[i] = MID;
      end
   endfunction

   function automatic void advance();
      for (int i = 0; i < NCH; i++) begin
`ifdef SERVO_SLEW_EN
         int d = tgt_m[i] - cur_m[i];
         if (d > STEP)       cur_m[i] += STEP;
         else if (d < -STEP) cur_m[i] -= STEP;
         else                cur_m[i] = tgt_m[i];
`else
         cur_m[i] = tgt_m[i];
`endif
      end
   endfunction

   function automatic logic [3:0] busy_m();
      logic [3:0] b = '0;
      for (int i = 0; i < NCH; i++) b[i] = (cur_m[i] != tgt_m[i]);
      return b;
   endfunction

   function automatic void snapshot_exp();
      for (int i = 0; i < NCH; i++) exp_w[i] = cur_m[i];
   endfunction

   // Starts at the sample where frame_start is seen; runs until the next
   // frame_start sample (bounded), counting high cycles and driving queued
   // commands / enable changes at the given frame offsets.
   task automatic run_frame();
      ok  = 1'b0;
      len = 0;
      for (int i = 0; i < NCH; i++) hi[i] = 0;
      for (int c = 0; c < P + 5; c++) begin
         for (int i = 0; i < NCH; i++) if (control[i]) hi[i]++;
         if (c == snap_at) begin
            snap_busy = busy;
            snap_ctrl = control;
         end
         cmd_valid = 1'b0;
         foreach (cmd_q[k]) begin
            if (cmd_q[k].off == c) begin
               cmd_valid = 1'b1;
               cmd_ch    = 3'(cmd_q[k].ch);
               cmd_width = CW'(cmd_q[k].w);
               apply_cmd(cmd_q[k].ch, cmd_q[k].w);
            end
         end
         if (c == drop_at) enable[1] = 1'b0;
         if (c == back_at) enable[1] = 1'b1;
         @(posedge clk); #1;
         len++;
         if (frame_start) begin
            ok = 1'b1;
            break;
         end
      end
      cmd_valid = 1'b0;
      cmd_q.delete();
      drop_at = -1;
      back_at = -1;
      snap_at = -1;
      if (ok) advance();
   endtask

   task automatic check_frame(string tag);
      n_vec++;
      if (!ok || len !== P) begin
         n_err++;
         $display("FAIL %s frame_len: got %0d (sync=%0d) expected %0d", tag, len, ok, P);
      end
      for (int i = 0; i < NCH; i++) begin
         n_vec++;
         if (hi[i] !== exp_w[i]) begin
            n_err++;
            $display("FAIL %s high_ch%0d: got %0d expected %0d", tag, i, hi[i], exp_w[i]);
         end
      end
      n_vec++;
      if (busy !== busy_m()) begin
         n_err++;
         $display("FAIL %s busy_at_frame: got %b expected %b", tag, busy, busy_m());
      end
   endtask

   task automatic release_reset(string tag);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (frame_start !== 1'b1) begin
         n_err++;
         $display("FAIL %s first_frame_start: got %b expected 1", tag, frame_start);
      end
      n_vec++;
      if (control !== enable) begin
         n_err++;
         $display("FAIL %s control_rise: got %h expected %h", tag, control, enable);
      end
      n_vec++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s cmd_ready: got %b expected 1", tag, cmd_ready);
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({control, frame_start, busy, cmd_ready} !== 10'b0) begin
         n_err++;
         $display("FAIL reset_state: got ctrl=%h fs=%b busy=%h rdy=%b expected all 0",
                  control, frame_start, busy, cmd_ready);
      end
      release_reset("reset");
      for (int f = 0; f < 2; f++) begin
         snapshot_exp();
         run_frame();
         check_frame("reset");
      end
   endtask

   task automatic test_write_ch1();
      snapshot_exp();
      cmd_q.push_back('{off: 299, ch: 1, w: 100});
      snap_at = 300;
      run_frame();
      check_frame("write_cur");
      n_vec++;
      if (snap_busy[1] !== 1'b1) begin
         n_err++;
         $display("FAIL write_busy: got %b expected 1", snap_busy[1]);
      end
      for (int f = 0; f < 3; f++) begin
         snapshot_exp();
         run_frame();
         check_frame("write_next");
      end
   endtask

   task automatic test_slew_ch2();
      snapshot_exp();
      cmd_q.push_back('{off: 100, ch: 2, w: 50});
      run_frame();
      check_frame("slew_cmd");
      for (int f = 0; f < 4; f++) begin
         snapshot_exp();
         run_frame();
         check_frame("slew_ramp");
      end
   endtask

   task automatic test_clamp();
      snapshot_exp();
      cmd_q.push_back('{off: 10, ch: 0, w: 10});
      cmd_q.push_back('{off: 20, ch: 3, w: 5000});
      cmd_q.push_back('{off: 30, ch: 5, w: 60});
      cmd_q.push_back('{off: 40, ch: 2, w: 64'h80_0032});
      cmd_q.push_back('{off: 50, ch: 7, w: 0});
      run_frame();
      check_frame("clamp_cmd");
      for (int f = 0; f < 4; f++) begin
         snapshot_exp();
         run_frame();
         check_frame("clamp");
      end
   endtask

   task automatic test_enable();
      snapshot_exp();
      drop_at = 20;
      back_at = 40;
      snap_at = 21;
      if (exp_w[1] > 21) exp_w[1] = 21;
      run_frame();
      check_frame("enable_drop");
      n_vec++;
      if (snap_ctrl[1] !== 1'b0) begin
         n_err++;
         $display("FAIL enable_latency: got %b expected 0", snap_ctrl[1]);
      end
      snapshot_exp();
      run_frame();
      check_frame("enable_back");
   endtask

   task automatic test_reset_mid();
      repeat (39) begin
         @(posedge clk); #1;
      end
      n_vec++;
      if (control !== 4'hF) begin
         n_err++;
         $display("FAIL midreset_pre: got %h expected f", control);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if ({control, frame_start, busy, cmd_ready} !== 10'b0) begin
         n_err++;
         $display("FAIL midreset_async: got ctrl=%h fs=%b busy=%h rdy=%b expected all 0",
                  control, frame_start, busy, cmd_ready);
      end
      repeat (3) @(posedge clk);
      release_reset("midreset");
      snapshot_exp();
      run_frame();
      check_frame("midreset");
   endtask

   task automatic test_random();
      for (int f = 0; f < 5; f++) begin
         snapshot_exp();
         for (int b = 0; b < 3; b++) begin
            cmd_t c;
            c.off = b * 300 + int'($urandom_range(0, 299));
            c.ch  = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) != 0) c.w = longint'($urandom_range(30, 120));
            else                           c.w = longint'($urandom & 32'hFF_FFFF);
            cmd_q.push_back(c);
         end
         // command in the boundary cycle itself
         cmd_q.push_back('{off: P - 2, ch: int'($urandom_range(0, 3)),
                           w: longint'($urandom_range(40, 110))});
         run_frame();
         check_frame("random");
      end
      snapshot_exp();
      run_frame();
      check_frame("random_tail");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_write_ch1();
      test_slew_ch2();
      test_clamp();
      test_enable();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
